// File: rtl/bcd_mod_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_mod_counter_pkg : shared BCD digit width, limits and to_bcd helper     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package bcd_mod_counter_pkg;

   localparam int BCD_W      = 4;
   localparam int MAX_DIGITS = 9;
   localparam int MAX_W      = BCD_W * MAX_DIGITS;

   typedef logic [BCD_W-1:0] bcd_digit_t;

   function automatic logic [MAX_W-1:0] to_bcd(input int value, input int digits);
      logic [MAX_W-1:0] r;
      int               v;
      r = '0;
      v = value;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (i < digits) begin
            r[i*BCD_W +: BCD_W] = bcd_digit_t'(v % 10);
            v = v / 10;
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mod_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_mod_counter_if : control inputs and count/carry outputs of one stage   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface bcd_mod_counter_if #(
   parameter int DIGITS = 2
);
   logic                  en;
   logic                  up;
   logic                  clr;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   count;
   logic                  co;
   logic                  load_err;

   modport master (
      output en, up, clr, load, load_val,
      input  count, co, load_err
   );

   modport slave (
      input  en, up, clr, load, load_val,
      output count, co, load_err
   );
endinterface
`default_nettype wire

// File: rtl/bcd_mod_counter_digit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_digit : one 0..9 digit with clear, load, increment and decrement       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bcd_digit
   import bcd_mod_counter_pkg::*;
(
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       inc,
   input  wire logic       dec,
   input  wire logic       ld,
   input  wire bcd_digit_t ld_val,
   input  wire logic       clr,
   output bcd_digit_t      q,
   output logic            cy,
   output logic            bw
);

   bcd_digit_t r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (ld) begin
         r_q <= ld_val;
      end else if (inc) begin
         r_q <= (r_q == bcd_digit_t'(9)) ? '0 : r_q + bcd_digit_t'(1);
      end else if (dec) begin
         r_q <= (r_q == '0) ? bcd_digit_t'(9) : r_q - bcd_digit_t'(1);
      end
   end

   assign q  = r_q;
   assign cy = inc & (r_q == bcd_digit_t'(9));
   assign bw = dec & (r_q == '0);

endmodule
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_mod_counter : cascadable up/down BCD counter wrapping at MOD           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bcd_mod_counter
   import bcd_mod_counter_pkg::*;
#(
   parameter int DIGITS = 2,
   parameter int MOD    = 60
) (
   input  wire logic          clk,
   input  wire logic          rst,
   bcd_mod_counter_if.slave   bus
);

   localparam int               W           = BCD_W * DIGITS;
   localparam logic [MAX_W-1:0] MOD_BCD_FULL = to_bcd(MOD - 1, DIGITS);
   localparam logic [W-1:0]     MOD_BCD_MAX = MOD_BCD_FULL[W-1:0];

   if ((DIGITS < 1) || (DIGITS > MAX_DIGITS) || (MOD < 2) || (MOD > 10**DIGITS)) begin : g_bad_params
      $error("bcd_mod_counter: MOD=%0d illegal for DIGITS=%0d", MOD, DIGITS);
   end

   logic [W-1:0]      w_count;
   logic [W-1:0]      w_ld_val;
   logic [DIGITS:0]   w_inc;
   logic [DIGITS:0]   w_dec;
   logic [DIGITS-1:0] w_digit_ok;
   logic              w_term_up;
   logic              w_term_dn;
   logic              w_wrap;
   logic              w_load_ok;
   logic              w_count_ok;
   logic              w_clr_all;
   logic              w_ld_all;
   logic              w_unused_top_ripple;
   logic              r_load_err;

   assign w_term_up  = (w_count == MOD_BCD_MAX);
   assign w_term_dn  = (w_count == '0);
   assign w_wrap     = bus.en & (bus.up ? w_term_up : w_term_dn);

   // Valid BCD compares in packed form exactly as its decimal value does.
   assign w_load_ok  = (&w_digit_ok) & (bus.load_val <= MOD_BCD_MAX);
   assign w_count_ok = ~bus.clr & ~bus.load;

   assign w_clr_all  = bus.clr | (w_count_ok & w_wrap & bus.up);
   assign w_ld_all   = ~bus.clr & ((bus.load & w_load_ok) | (w_count_ok & w_wrap & ~bus.up));
   assign w_ld_val   = bus.load ? bus.load_val : MOD_BCD_MAX;

   assign w_inc[0]   = w_count_ok & bus.en & ~w_wrap &  bus.up;
   assign w_dec[0]   = w_count_ok & bus.en & ~w_wrap & ~bus.up;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign w_digit_ok[i] = (bus.load_val[i*BCD_W +: BCD_W] <= bcd_digit_t'(9));

      bcd_digit u_digit (
         .clk    (clk),
         .rst    (rst),
         .inc    (w_inc[i]),
         .dec    (w_dec[i]),
         .ld     (w_ld_all),
         .ld_val (w_ld_val[i*BCD_W +: BCD_W]),
         .clr    (w_clr_all),
         .q      (w_count[i*BCD_W +: BCD_W]),
         .cy     (w_inc[i+1]),
         .bw     (w_dec[i+1])
      );
   end

   // Top-digit ripple never fires: the terminal compare wraps first.
   assign w_unused_top_ripple = w_inc[DIGITS] | w_dec[DIGITS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_load_err <= 1'b0;
      end else begin
         r_load_err <= ~bus.clr & bus.load & ~w_load_ok;
      end
   end

   assign bus.count    = w_count;
   assign bus.co       = w_wrap;
   assign bus.load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bcd_mod_counter : directed + random checks against a decimal model      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bcd_mod_counter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bcd_mod_counter_if #(.DIGITS(2)) bus ();
   bcd_mod_counter_if #(.DIGITS(2)) lo_if ();
   bcd_mod_counter_if #(.DIGITS(2)) hi_if ();

   bcd_mod_counter #(.DIGITS(2), .MOD(60)) u_dut (.clk(clk), .rst(rst), .bus(bus));
   bcd_mod_counter #(.DIGITS(2), .MOD(60)) u_lo  (.clk(clk), .rst(rst), .bus(lo_if));
   bcd_mod_counter #(.DIGITS(2), .MOD(24)) u_hi  (.clk(clk), .rst(rst), .bus(hi_if));

   assign hi_if.en = lo_if.co;

   int total = 0;
   int bad   = 0;
   int m_val;
   int m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int bcd(input int v);
      int r = 0;
      for (int i = 0; i < 8; i++) begin
         r = r | ((v % 10) << (4 * i));
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int exp_co();
      if (!bus.en) return 0;
      return bus.up ? int'(m_val == 59) : int'(m_val == 0);
   endfunction

   // Decimal model of one clock edge of a MOD-60 counter.
   function automatic void model_edge();
      int lv, d, val;
      bit ok;
      if (bus.clr) begin
         m_val = 0;
         m_err = 0;
      end else if (bus.load) begin
         lv  = int'(bus.load_val);
         ok  = 1'b1;
         val = 0;
         for (int i = 1; i >= 0; i--) begin
            d = (lv >> (4 * i)) & 15;
            if (d > 9) ok = 1'b0;
            val = val * 10 + d;
         end
         if (ok && val < 60) begin
            m_val = val;
            m_err = 0;
         end else begin
            m_err = 1;
         end
      end else begin
         if (bus.en) m_val = bus.up ? (m_val + 1) % 60 : (m_val + 59) % 60;
         m_err = 0;
      end
   endfunction

   task automatic step(input string tag);
      @(negedge clk);
      check({tag, "_count"}, 32'(bus.count), 32'(bcd(m_val)));
      check({tag, "_co"}, 32'(bus.co), 32'(exp_co()));
      check({tag, "_load_err"}, 32'(bus.load_err), 32'(m_err));
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_load(input logic [7:0] v);
      bus.load = 1'b1;
      bus.load_val = v;
      step("load");
      bus.load = 1'b0;
   endtask

   int hi_co_cnt;

   initial begin
      rst = 1'b1;
      bus.en = 1'b1; bus.up = 1'b1; bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = '0;
      lo_if.en = 1'b0; lo_if.up = 1'b1; lo_if.clr = 1'b0; lo_if.load = 1'b0; lo_if.load_val = '0;
      hi_if.up = 1'b1; hi_if.clr = 1'b0; hi_if.load = 1'b0; hi_if.load_val = '0;
      m_val = 0;
      m_err = 0;

      #1;
      check("rst_count", 32'(bus.count), 32'h0);
      check("rst_load_err", 32'(bus.load_err), 32'h0);
      check("rst_co_up", 32'(bus.co), 32'h0);
      bus.up = 1'b0;
      #1;
      check("rst_co_down", 32'(bus.co), 32'h1);
      bus.up = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Full up sequence including the wrap back to 00.
      for (int i = 0; i < 61; i++) step("up");

      bus.clr = 1'b1;
      step("clr");
      bus.clr = 1'b0;
      bus.up = 1'b0;
      for (int i = 0; i < 3; i++) step("down");
      do_load(8'h10);
      step("down_borrow");
      step("down_borrow");

      bus.en = 1'b0;
      do_load(8'h47); step("ld47"); step("ld47");
      do_load(8'h60); step("ld60"); step("ld60");
      do_load(8'h3A); step("ld3a"); step("ld3a");

      do_load(8'h33);
      bus.clr = 1'b1; bus.load = 1'b1; bus.load_val = 8'h47; bus.en = 1'b1; bus.up = 1'b1;
      step("clr_prio");
      bus.clr = 1'b0; bus.load = 1'b0; bus.en = 1'b0;
      step("clr_prio");

      do_load(8'h59);
      bus.en = 1'b1; bus.up = 1'b1;
      do_load(8'h12);
      bus.en = 1'b0;
      step("load_prio");

      // Asynchronous reset landing between edges.
      do_load(8'h25);
      bus.en = 1'b1;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_count", 32'(bus.count), 32'h0);
      check("async_rst_err", 32'(bus.load_err), 32'h0);
      @(posedge clk);
      #1;
      check("rst_hold_count", 32'(bus.count), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      m_val = 0;
      m_err = 0;
      @(posedge clk);
      model_edge();
      #1;

      for (int i = 0; i < 3000; i++) begin
         bus.en       = ($urandom % 4) != 0;
         bus.up       = $urandom % 2;
         bus.clr      = ($urandom % 32) == 0;
         bus.load     = ($urandom % 10) == 0;
         bus.load_val = (($urandom % 3) == 0) ? 8'($urandom) : 8'(bcd($urandom % 60));
         step("rnd");
      end
      bus.en = 1'b0; bus.clr = 1'b0; bus.load = 1'b0;

      // Minutes stage cascaded into hours stage through co -> en.
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      lo_if.en = 1'b1;
      hi_co_cnt = 0;
      for (int t = 0; t <= 1440; t++) begin
         @(negedge clk);
         check("casc_lo", 32'(lo_if.count), 32'(bcd(t % 60)));
         check("casc_hi", 32'(hi_if.count), 32'(bcd((t / 60) % 24)));
         check("casc_hi_co", 32'(hi_if.co), 32'((t % 1440) == 1439));
         if (hi_if.co && t < 1440) hi_co_cnt++;
         @(posedge clk);
      end
      check("casc_hi_co_count", 32'(hi_co_cnt), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
